ddc_frame_packer: RTL and testbench
===================================

Name: ddc_frame_packer

Overview:
- Downstream consumer of the per-channel I/Q accumulators.
- On each accumulation-done strobe, snapshots N_CH pairs of 48-bit accumulated I/Q values.
- Serialises each snapshot as one framed AXI4-Stream packet (header word + 2*N_CH data words) toward the DMA.
- Provides one-deep pending buffering, back-to-back frames, and overflow/drop accounting.

Parameters:
- N_CH, 4, number of channels per snapshot (1..255).
- ACC_WIDTH, 48, width of each accumulated I or Q value (≤ 64).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- valid_in  in  1  single-cycle strobe: i_in/q_in hold a completed accumulation.
- i_in  in  N_CH*ACC_WIDTH  I values; channel k at bits [k*ACC_WIDTH +: ACC_WIDTH].
- q_in  in  N_CH*ACC_WIDTH  Q values; same packing as i_in.
- m_axis_tdata  out  64  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last word of frame.
- clr_status  in  1  clears overflow and drop_count.
- overflow  out  1  sticky; a snapshot was dropped.
- drop_count  out  16  dropped snapshots, saturating at 0xFFFF.

Behaviour:
- Reset: FSM=IDLE, pending empty, frame_seq=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0, drop_count=0.
- Pending buffer (one entry):
  - valid_in with pending empty → capture i_in/q_in, set pend_full.
  - valid_in with pend_full, and pending not transferring to the active register this cycle → snapshot dropped; drop_count+1 (saturating); overflow←1.
  - valid_in in the same cycle the pending entry transfers to active → capture; no drop.
- Active register: loaded from pending on a transfer; pend_full clears on transfer unless recaptured in the same cycle.
- FSM states IDLE, HEADER, DATA:
  - IDLE: if pend_full → transfer, go to HEADER.
  - HEADER: tvalid=1, tdata = {16'hDDC0, 8'h00, N_CH[7:0], frame_seq[31:0]}, tlast=0. On handshake: frame_seq+1 (wraps 2^32→0), word index w←0, go to DATA.
  - DATA: tvalid=1. Word w (0..2*N_CH-1) carries channel w>>1: I when w is even, Q when w is odd, sign-extended ACC_WIDTH→64. tlast=1 only at w=2*N_CH-1.
  - Handshake on a non-last word → w+1.
  - Handshake on the last word → if pend_full, transfer and go to HEADER (no idle cycle between frames); else go to IDLE with tvalid=0.
- Latency: valid_in high in cycle t with FSM idle and pending empty → header tvalid high in cycle t+2.
- Frame length: 1+2*N_CH beats.
- AXI-Stream rules:
  - tdata/tlast held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - tvalid does not depend combinationally on tready.
- Status:
  - clr_status zeroes overflow and drop_count.
  - If clr_status and a drop coincide, the drop wins: overflow=1, drop_count=1.
- Reset mid-frame: frame is abandoned; tvalid=0 on the following cycle; pending and counters cleared; no partial tlast emitted.

Test Plan:
- N_CH=4, tready=1, one valid_in with I0=48'h000000000005 and Q0=48'hFFFFFFFFFFFB → header tvalid at t+2, tdata=64'hDDC0_0004_0000_0000; 9 beats; word1=64'h5; word2=64'hFFFF_FFFF_FFFF_FFFB; tlast only on beat 9.
- Two valid_in strobes 3 cycles apart, tready=1 → two frames; frame 2 header starts the cycle after frame 1 tlast; frame_seq=0 then 1; drop_count=0.
- tready=0 held for 20 cycles; valid_in at cycles 0, 5 and 10 → first frame stalled with header stable; second snapshot pending; third dropped; overflow=1, drop_count=1. After tready=1, exactly 2 frames are emitted.
- Random tready toggling (50%) over 100 frames → scoreboard matches every beat; tdata stable during stalls; no drops when strobe spacing exceeds the frame length.
- drop_count preloaded to 0xFFFF via repeated overflow → stays at 0xFFFF. Then clr_status together with a drop → overflow=1, drop_count=1.
- rst asserted during DATA beat 3 → next cycle tvalid=0 and frame_seq=0; a new valid_in produces a full frame with frame_seq=0.

Source files
------------

// File: rtl/ddc_frame_packer.sv
// ddc_frame_packer: snapshots N_CH accumulated I/Q pairs on each valid_in
// strobe and serialises each snapshot as one AXI4-Stream frame
// (header word + 2*N_CH sign-extended data words). A one-entry pending
// buffer lets a new snapshot wait while the previous frame drains, so
// frames can run back to back. Snapshots that find the buffer full are
// dropped and counted.
module ddc_frame_packer #(
   parameter int N_CH      = 4,
   parameter int ACC_WIDTH = 48
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_in,
   input  logic [N_CH*ACC_WIDTH-1:0]   i_in,
   input  logic [N_CH*ACC_WIDTH-1:0]   q_in,
   output logic [63:0]                 m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   input  logic                        clr_status,
   output logic                        overflow,
   output logic [15:0]                 drop_count
);

   localparam int              NWORDS = 2 * N_CH;
   localparam int              WW     = $clog2(NWORDS + 1);
   localparam logic [WW-1:0]   LAST_W = WW'(NWORDS - 1);
   localparam logic [7:0]      NCH8   = 8'(N_CH);

   typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

   state_t                      state, state_nxt;
   logic [WW-1:0]               w, w_nxt;
   logic [31:0]                 frame_seq;
   logic                        seq_inc;
   logic                        xfer;
   logic                        last_w;
   logic                        drop;

   logic                        pend_full;
   logic [N_CH*ACC_WIDTH-1:0]   pend_i, pend_q;
   logic [N_CH*ACC_WIDTH-1:0]   act_i, act_q;

   logic signed [ACC_WIDTH-1:0] sel;
   logic signed [63:0]          sel_ext;

   assign last_w = (w == LAST_W);

   // A snapshot is dropped only when the pending slot is occupied and is
   // not being handed to the active register in this same cycle.
   assign drop = valid_in && pend_full && !xfer;

   // Next-state logic. In HEADER/DATA tvalid is always 1, so tready alone
   // marks a handshake; the last data handshake chains straight into the
   // next header when a snapshot is already waiting.
   always_comb begin
      state_nxt = state;
      w_nxt     = w;
      xfer      = 1'b0;
      seq_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (pend_full) begin
               xfer      = 1'b1;
               state_nxt = HEADER;
            end
         end
         HEADER: begin
            if (m_axis_tready) begin
               seq_inc   = 1'b1;
               w_nxt     = '0;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (m_axis_tready) begin
               if (last_w) begin
                  if (pend_full) begin
                     xfer      = 1'b1;
                     state_nxt = HEADER;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  w_nxt = w + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pick channel w>>1 from the active snapshot: even words are I, odd are Q.
   always_comb begin
      sel = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (k == int'(w >> 1)) begin
            sel = w[0] ? act_q[k*ACC_WIDTH +: ACC_WIDTH]
                       : act_i[k*ACC_WIDTH +: ACC_WIDTH];
         end
      end
      sel_ext = 64'(sel);
   end

   // Stream outputs are a pure function of registered state, so they stay
   // stable under back-pressure and tvalid never looks at tready.
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      case (state)
         HEADER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {16'hDDC0, 8'h00, NCH8, frame_seq};
         end
         DATA: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = sel_ext;
            m_axis_tlast  = last_w;
         end
         default: ;
      endcase
   end

   // State and word-index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         w     <= '0;
      end else begin
         state <= state_nxt;
         w     <= w_nxt;
      end
   end

   // Frame sequence number advances on each accepted header; wraps at 2^32.
   always_ff @(posedge clk) begin
      if (rst)          frame_seq <= '0;
      else if (seq_inc) frame_seq <= frame_seq + 32'd1;
   end

   // Pending slot: capture when empty or when the current entry moves to
   // active this cycle; otherwise release it on a transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_full <= 1'b0;
         pend_i    <= '0;
         pend_q    <= '0;
      end else if (valid_in && (!pend_full || xfer)) begin
         pend_full <= 1'b1;
         pend_i    <= i_in;
         pend_q    <= q_in;
      end else if (xfer) begin
         pend_full <= 1'b0;
      end
   end

   // Active snapshot being serialised.
   always_ff @(posedge clk) begin
      if (rst) begin
         act_i <= '0;
         act_q <= '0;
      end else if (xfer) begin
         act_i <= pend_i;
         act_q <= pend_q;
      end
   end

   // Drop accounting: a coincident drop beats clr_status, leaving count 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_status)                drop_count <= 16'd1;
         else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (clr_status) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule

// File: tb/tb_ddc_frame_packer.sv
// Bench for ddc_frame_packer: per-scenario tasks, random snapshots, and a
// frame-level reference model (header + sign-extended I/Q words per snapshot).
module tb_ddc_frame_packer;

   localparam int NCH  = 4;
   localparam int AW   = 48;
   localparam int FLEN = 1 + 2*NCH;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              valid_in = 1'b0;
   logic              tready = 1'b0;
   logic              clr = 1'b0;
   logic [NCH*AW-1:0] i_in = '0;
   logic [NCH*AW-1:0] q_in = '0;
   logic [63:0]       tdata;
   logic              tvalid, tlast, overflow;
   logic [15:0]       drop_count;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int stall_viol = 0;

   typedef struct {logic [63:0] data; logic last; int cyc;} beat_t;
   beat_t       obs_q[$];
   logic [64:0] exp_q[$];

   logic        prev_stall = 1'b0;
   logic [63:0] prev_data  = '0;
   logic        prev_last  = 1'b0;

   ddc_frame_packer #(.N_CH(NCH), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .i_in(i_in), .q_in(q_in),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .clr_status(clr), .overflow(overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Beat recorder and stall-stability watcher, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall && (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last))
            stall_viol <= stall_viol + 1;
         if (tvalid && tready) obs_q.push_back('{tdata, tlast, cyc});
      end
      prev_stall <= !rst && tvalid && !tready;
      prev_data  <= tdata;
      prev_last  <= tlast;
   end

   function automatic logic [63:0] sx(input logic [AW-1:0] v);
      return v[AW-1] ? {{(64-AW){1'b1}}, v} : {{(64-AW){1'b0}}, v};
   endfunction

   // Reference model: one snapshot becomes one frame of FLEN words.
   function automatic void add_frame(input logic [31:0] seq, input logic [NCH*AW-1:0] ri, input logic [NCH*AW-1:0] rq);
      exp_q.push_back({1'b0, 16'hDDC0, 8'h00, 8'(NCH), seq});
      for (int k = 0; k < NCH; k++) begin
         exp_q.push_back({1'b0, sx(ri[k*AW +: AW])});
         exp_q.push_back({(k == NCH-1), sx(rq[k*AW +: AW])});
      end
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rand_snap(output logic [NCH*AW-1:0] ri, output logic [NCH*AW-1:0] rq);
      for (int k = 0; k < NCH; k++) begin
         ri[k*AW +: AW] = AW'({$urandom(), $urandom()});
         rq[k*AW +: AW] = AW'({$urandom(), $urandom()});
      end
   endtask

   task automatic strobe(input logic [NCH*AW-1:0] ri, input logic [NCH*AW-1:0] rq);
      i_in = ri; q_in = rq; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; valid_in = 1'b0; clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic wait_beats(input int n, input int budget);
      int k = 0;
      while (obs_q.size() < n && k < budget) begin tick(); k++; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      n_checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", tvalid); else n_pass++;
      n_checks++; if (tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", tlast); else n_pass++;
      n_checks++; if (tdata !== 64'h0) $display("FAIL reset_tdata: got %h want 0", tdata); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
      n_checks++; if (drop_count !== 16'h0) $display("FAIL reset_drop_count: got %h want 0", drop_count); else n_pass++;
   endtask

   task automatic test_basic();
      logic [NCH*AW-1:0] ri, rq;
      int t;
      do_reset();
      tready = 1'b1;
      rand_snap(ri, rq);
      ri[0 +: AW] = 48'h000000000005;
      rq[0 +: AW] = 48'hFFFFFFFFFFFB;
      add_frame(32'd0, ri, rq);
      t = cyc;
      strobe(ri, rq);
      @(negedge clk);
      n_checks++; if (tvalid !== 1'b0) $display("FAIL basic_early_tvalid: got %b want 0 at t+1", tvalid); else n_pass++;
      @(negedge clk);
      n_checks++; if (tvalid !== 1'b1) $display("FAIL basic_latency: got tvalid %b want 1 at t+2", tvalid); else n_pass++;
      n_checks++; if (tdata !== 64'hDDC0_0004_0000_0000) $display("FAIL basic_header: got %h want %h", tdata, 64'hDDC0_0004_0000_0000); else n_pass++;
      wait_beats(FLEN, 50);
      n_checks++; if (obs_q.size() !== FLEN) $display("FAIL basic_beats: got %0d want %0d", obs_q.size(), FLEN); else n_pass++;
      for (int j = 0; j < exp_q.size(); j++) begin
         n_checks++;
         if (j >= obs_q.size()) $display("FAIL basic_beat%0d: got none want %h", j, exp_q[j]);
         else if ({obs_q[j].last, obs_q[j].data} !== exp_q[j]) $display("FAIL basic_beat%0d: got %h want %h", j, {obs_q[j].last, obs_q[j].data}, exp_q[j]);
         else n_pass++;
      end
      if (obs_q.size() >= 3) begin
         n_checks++; if (obs_q[0].cyc !== t + 2) $display("FAIL basic_header_cycle: got %0d want %0d", obs_q[0].cyc, t + 2); else n_pass++;
         n_checks++; if (obs_q[1].data !== 64'h5) $display("FAIL basic_word1: got %h want 5", obs_q[1].data); else n_pass++;
         n_checks++; if (obs_q[2].data !== 64'hFFFF_FFFF_FFFF_FFFB) $display("FAIL basic_word2: got %h want fffffffffffffffb", obs_q[2].data); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [NCH*AW-1:0] ai, aq, bi, bq;
      do_reset();
      tready = 1'b1;
      rand_snap(ai, aq); rand_snap(bi, bq);
      add_frame(32'd0, ai, aq); add_frame(32'd1, bi, bq);
      strobe(ai, aq);
      tick(); tick();
      strobe(bi, bq);
      wait_beats(2*FLEN, 80);
      n_checks++; if (obs_q.size() !== 2*FLEN) $display("FAIL b2b_beats: got %0d want %0d", obs_q.size(), 2*FLEN); else n_pass++;
      for (int j = 0; j < exp_q.size(); j++) begin
         n_checks++;
         if (j >= obs_q.size()) $display("FAIL b2b_beat%0d: got none want %h", j, exp_q[j]);
         else if ({obs_q[j].last, obs_q[j].data} !== exp_q[j]) $display("FAIL b2b_beat%0d: got %h want %h", j, {obs_q[j].last, obs_q[j].data}, exp_q[j]);
         else n_pass++;
      end
      if (obs_q.size() > FLEN) begin
         n_checks++; if (obs_q[FLEN].cyc !== obs_q[FLEN-1].cyc + 1) $display("FAIL b2b_gap: header2 cycle %0d want %0d", obs_q[FLEN].cyc, obs_q[FLEN-1].cyc + 1); else n_pass++;
      end
      n_checks++; if (drop_count !== 16'h0) $display("FAIL b2b_drop_count: got %h want 0", drop_count); else n_pass++;
   endtask

   task automatic test_stall_drop();
      logic [NCH*AW-1:0] ai, aq, bi, bq, ci, cq;
      int v0;
      do_reset();
      v0 = stall_viol;
      tready = 1'b0;
      rand_snap(ai, aq); rand_snap(bi, bq); rand_snap(ci, cq);
      add_frame(32'd0, ai, aq); add_frame(32'd1, bi, bq);
      strobe(ai, aq); repeat (4) tick();
      strobe(bi, bq); repeat (4) tick();
      strobe(ci, cq); repeat (9) tick();
      n_checks++; if (tvalid !== 1'b1) $display("FAIL stall_tvalid: got %b want 1", tvalid); else n_pass++;
      n_checks++; if (tdata !== exp_q[0][63:0]) $display("FAIL stall_header: got %h want %h", tdata, exp_q[0][63:0]); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL stall_overflow: got %b want 1", overflow); else n_pass++;
      n_checks++; if (drop_count !== 16'd1) $display("FAIL stall_drop_count: got %0d want 1", drop_count); else n_pass++;
      tready = 1'b1;
      repeat (40) tick();
      n_checks++; if (obs_q.size() !== 2*FLEN) $display("FAIL stall_beats: got %0d want %0d", obs_q.size(), 2*FLEN); else n_pass++;
      for (int j = 0; j < exp_q.size(); j++) begin
         n_checks++;
         if (j >= obs_q.size()) $display("FAIL stall_beat%0d: got none want %h", j, exp_q[j]);
         else if ({obs_q[j].last, obs_q[j].data} !== exp_q[j]) $display("FAIL stall_beat%0d: got %h want %h", j, {obs_q[j].last, obs_q[j].data}, exp_q[j]);
         else n_pass++;
      end
      n_checks++; if (stall_viol - v0 !== 0) $display("FAIL stall_stability: got %0d unstable cycles want 0", stall_viol - v0); else n_pass++;
   endtask

   task automatic test_random();
      logic [NCH*AW-1:0] ri, rq;
      int v0, gap;
      do_reset();
      v0 = stall_viol;
      for (int f = 0; f < 100; f++) begin
         rand_snap(ri, rq);
         add_frame(32'(f), ri, rq);
         tready = 1'($urandom_range(0, 1));
         strobe(ri, rq);
         gap = 40 + int'($urandom_range(0, 7));
         for (int c = 0; c < gap; c++) begin
            tready = 1'($urandom_range(0, 1));
            tick();
         end
      end
      tready = 1'b1;
      wait_beats(100*FLEN, 200);
      n_checks++; if (obs_q.size() !== 100*FLEN) $display("FAIL rand_beats: got %0d want %0d", obs_q.size(), 100*FLEN); else n_pass++;
      for (int j = 0; j < exp_q.size(); j++) begin
         n_checks++;
         if (j >= obs_q.size()) $display("FAIL rand_beat%0d: got none want %h", j, exp_q[j]);
         else if ({obs_q[j].last, obs_q[j].data} !== exp_q[j]) $display("FAIL rand_beat%0d: got %h want %h", j, {obs_q[j].last, obs_q[j].data}, exp_q[j]);
         else n_pass++;
      end
      n_checks++; if (stall_viol - v0 !== 0) $display("FAIL rand_stability: got %0d unstable cycles want 0", stall_viol - v0); else n_pass++;
      n_checks++; if (drop_count !== 16'h0) $display("FAIL rand_drop_count: got %0d want 0", drop_count); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL rand_overflow: got %b want 0", overflow); else n_pass++;
   endtask

   task automatic test_saturate_clear();
      logic [NCH*AW-1:0] ri, rq;
      int ns, expd;
      do_reset();
      tready = 1'b0;
      rand_snap(ri, rq);
      i_in = ri; q_in = rq;
      ns = 65545;
      // Two strobes fill active and pending; every later one is a drop.
      expd = (ns - 2 > 65535) ? 65535 : ns - 2;
      valid_in = 1'b1;
      repeat (ns) tick();
      valid_in = 1'b0;
      n_checks++; if (drop_count !== 16'(expd)) $display("FAIL sat_count: got %h want %h", drop_count, 16'(expd)); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL sat_overflow: got %b want 1", overflow); else n_pass++;
      strobe(ri, rq);
      n_checks++; if (drop_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", drop_count); else n_pass++;
      clr = 1'b1;
      strobe(ri, rq);
      clr = 1'b0;
      n_checks++; if (overflow !== 1'b1) $display("FAIL clr_drop_overflow: got %b want 1", overflow); else n_pass++;
      n_checks++; if (drop_count !== 16'd1) $display("FAIL clr_drop_count: got %h want 1", drop_count); else n_pass++;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_checks++; if (overflow !== 1'b0) $display("FAIL clr_overflow: got %b want 0", overflow); else n_pass++;
      n_checks++; if (drop_count !== 16'd0) $display("FAIL clr_count: got %h want 0", drop_count); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      logic [NCH*AW-1:0] xi, xq, yi, yq;
      int lasts;
      do_reset();
      tready = 1'b1;
      rand_snap(xi, xq); rand_snap(yi, yq);
      strobe(xi, xq);
      wait_beats(3, 30);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (tvalid !== 1'b0) $display("FAIL midrst_tvalid: got %b want 0", tvalid); else n_pass++;
      n_checks++; if (tlast !== 1'b0) $display("FAIL midrst_tlast: got %b want 0", tlast); else n_pass++;
      lasts = 0;
      foreach (obs_q[j]) if (obs_q[j].last) lasts++;
      n_checks++; if (lasts !== 0) $display("FAIL midrst_partial_last: got %0d want 0", lasts); else n_pass++;
      obs_q.delete(); exp_q.delete();
      add_frame(32'd0, yi, yq);
      strobe(yi, yq);
      wait_beats(FLEN, 40);
      n_checks++; if (obs_q.size() !== FLEN) $display("FAIL midrst_beats: got %0d want %0d", obs_q.size(), FLEN); else n_pass++;
      for (int j = 0; j < exp_q.size(); j++) begin
         n_checks++;
         if (j >= obs_q.size()) $display("FAIL midrst_beat%0d: got none want %h", j, exp_q[j]);
         else if ({obs_q[j].last, obs_q[j].data} !== exp_q[j]) $display("FAIL midrst_beat%0d: got %h want %h", j, {obs_q[j].last, obs_q[j].data}, exp_q[j]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall_drop();
      test_random();
      test_saturate_clear();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
